hires_rd_responder: RTL and testbench

- Downstream consumer of the hi-res graphics readback path.
- On a Z80 IN from the hi-res data port, it requests a bus WAIT and captures the byte from hires_dout when hires_dout_rdy pulses.
- It then drives that byte onto the TRS data bus and holds it until the IN strobe ends.
- It owns the read-side bus handshake, a glitch filter, a timeout fallback and sticky error status.

---
 rtl/hires_rd_responder.sv | 152 +++++++++++++++
 tb/tb_hires_rd_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hires_rd_responder.sv
// Hi-res readback responder: answers a Z80 IN on the hi-res data port,
// stalling the bus with WAIT until the readback byte arrives.
module hires_rd_responder #(
    parameter logic [7:0] PORT           = 8'h82,
    parameter int         FILTER_LEN     = 3,
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [7:0] TIMEOUT_DATA   = 8'hFF
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [15:0] TRS_A,
    input  logic        TRS_IN,
    input  logic [7:0]  hires_dout,
    input  logic        hires_dout_rdy,
    output logic        trs_wait,
    output logic [7:0]  trs_dout,
    output logic        trs_dout_oe,
    output logic        timeout_err,
    output logic        abort_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s2_q;
    logic          inq_q, inq_d;
    logic          inprev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_q, pend_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    dout_q, dout_d;
    logic          terr_q, terr_d;
    logic          aerr_q, aerr_d;
    logic          in_sync;
    logic          start;
    logic          unused_addr_hi;

    assign in_sync        = s2_q;
    assign unused_addr_hi = ^TRS_A[15:8];
    assign start          = inq_q & ~inprev_q & (TRS_A[7:0] == PORT);

    always_comb begin
        inq_d  = inq_q;
        fcnt_d = '0;
        if (in_sync != inq_q) begin
            if (fcnt_q == FMAX) begin
                inq_d = in_sync;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Capture runs regardless of FSM state so an early rdy is not lost
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        data_d  = data_q;
        terr_d  = terr_q;
        aerr_d  = aerr_q;
        if (!in_sync) begin
            pend_d = 1'b0;
        end else if (hires_dout_rdy) begin
            pend_d = 1'b1;
            data_d = hires_dout;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (pend_q) begin
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_WAIT;
                        timer_d = '0;
                    end
                end
            end
            S_WAIT: begin
                if (pend_q || hires_dout_rdy) begin
                    state_d = S_DRIVE;
                    if (hires_dout_rdy) begin
                        data_d = hires_dout;
                    end
                end else if (!inq_q) begin
                    state_d = S_IDLE;
                    aerr_d  = 1'b1;
                end else if (timer_q == TMAX) begin
                    state_d = S_DRIVE;
                    data_d  = TIMEOUT_DATA;
                    terr_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DRIVE: begin
                if (!inq_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        dout_d = (state_d == S_DRIVE) ? data_d : dout_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= S_IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            inq_q    <= 1'b0;
            inprev_q <= 1'b0;
            fcnt_q   <= '0;
            timer_q  <= '0;
            pend_q   <= 1'b0;
            data_q   <= 8'h00;
            dout_q   <= 8'h00;
            terr_q   <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= ~TRS_IN;
            s2_q     <= s1_q;
            inq_q    <= inq_d;
            inprev_q <= inq_q;
            fcnt_q   <= fcnt_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            dout_q   <= dout_d;
            terr_q   <= terr_d;
            aerr_q   <= aerr_d;
        end
    end

    assign trs_wait    = (state_q == S_WAIT);
    assign trs_dout_oe = (state_q == S_DRIVE);
    assign trs_dout    = dout_q;
    assign timeout_err = terr_q;
    assign abort_err   = aerr_q;

endmodule

// File: tb/tb_hires_rd_responder.sv
// Directed bench for hires_rd_responder: segment table of per-cycle
// stimulus and expected outputs, plus hand-written reset sequences.
module tb_hires_rd_responder;

    logic        clk;
    logic        srst;
    logic [15:0] TRS_A;
    logic        TRS_IN;
    logic [7:0]  hires_dout;
    logic        hires_dout_rdy;
    logic        trs_wait;
    logic [7:0]  trs_dout;
    logic        trs_dout_oe;
    logic        timeout_err;
    logic        abort_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        int         len;
        logic       rst;
        logic       in_n;
        logic [7:0] addr;
        logic       rdy;
        logic [7:0] dat;
        logic       ew;
        logic       eo;
        logic [7:0] ed;
        logic       et;
        logic       ea;
    } seg_t;

    seg_t tbl[$];

    hires_rd_responder dut (
        .clk            (clk),
        .srst           (srst),
        .TRS_A          (TRS_A),
        .TRS_IN         (TRS_IN),
        .hires_dout     (hires_dout),
        .hires_dout_rdy (hires_dout_rdy),
        .trs_wait       (trs_wait),
        .trs_dout       (trs_dout),
        .trs_dout_oe    (trs_dout_oe),
        .timeout_err    (timeout_err),
        .abort_err      (abort_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic seg_t mk(input string nm, input int len,
                                input logic rst, input logic in_n,
                                input logic [7:0] addr, input logic rdy,
                                input logic [7:0] dat, input logic ew,
                                input logic eo, input logic [7:0] ed,
                                input logic et, input logic ea);
        seg_t s;
        s.nm = nm; s.len = len; s.rst = rst; s.in_n = in_n;
        s.addr = addr; s.rdy = rdy; s.dat = dat; s.ew = ew;
        s.eo = eo; s.ed = ed; s.et = et; s.ea = ea;
        return s;
    endfunction

    task automatic step(input seg_t s);
        logic [11:0] got, exp;
        for (int i = 0; i < s.len; i++) begin
            srst           = s.rst;
            TRS_IN         = s.in_n;
            TRS_A          = {8'h00, s.addr};
            hires_dout_rdy = s.rdy;
            hires_dout     = s.dat;
            @(posedge clk);
            #1;
            got = {trs_wait, trs_dout_oe, trs_dout, timeout_err, abort_err};
            exp = {s.ew, s.eo, s.ed, s.et, s.ea};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cyc %0d: got w=%b oe=%b d=%h te=%b ae=%b, want w=%b oe=%b d=%h te=%b ae=%b",
                         s.nm, i, trs_wait, trs_dout_oe, trs_dout,
                         timeout_err, abort_err, s.ew, s.eo, s.ed,
                         s.et, s.ea);
            end
        end
    endtask

    initial begin
        srst           = 1'b1;
        TRS_IN         = 1'b1;
        TRS_A          = 16'h0000;
        hires_dout     = 8'h00;
        hires_dout_rdy = 1'b0;

        // reset state
        step(mk("reset", 3, 1, 1, 8'h82, 0, 8'h00, 0, 0, 8'h00, 0, 0));

        // normal read, rdy three cycles after qualification
        tbl.push_back(mk("n_qual",  5, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk("n_wait",  3, 0, 0, 8'h82, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk("n_rdy",   1, 0, 0, 8'h82, 1, 8'h5A, 0, 1, 8'h5A, 0, 0));
        tbl.push_back(mk("n_drv",  31, 0, 0, 8'h82, 0, 8'h00, 0, 1, 8'h5A, 0, 0));
        tbl.push_back(mk("n_fall",  5, 0, 1, 8'h82, 0, 8'h00, 0, 1, 8'h5A, 0, 0));
        tbl.push_back(mk("n_rel",   5, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'h5A, 0, 0));
        // rdy before qualification
        tbl.push_back(mk("e_pre",   2, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'h5A, 0, 0));
        tbl.push_back(mk("e_rdy",   1, 0, 0, 8'h82, 1, 8'hC3, 0, 0, 8'h5A, 0, 0));
        tbl.push_back(mk("e_qual",  2, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'h5A, 0, 0));
        tbl.push_back(mk("e_drv",   5, 0, 0, 8'h82, 0, 8'h00, 0, 1, 8'hC3, 0, 0));
        tbl.push_back(mk("e_fall",  5, 0, 1, 8'h82, 0, 8'h00, 0, 1, 8'hC3, 0, 0));
        tbl.push_back(mk("e_rel",   5, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'hC3, 0, 0));
        // timeout
        tbl.push_back(mk("t_qual",  5, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'hC3, 0, 0));
        tbl.push_back(mk("t_wait", 64, 0, 0, 8'h82, 0, 8'h00, 1, 0, 8'hC3, 0, 0));
        tbl.push_back(mk("t_drv",   6, 0, 0, 8'h82, 0, 8'h00, 0, 1, 8'hFF, 1, 0));
        tbl.push_back(mk("t_fall",  5, 0, 1, 8'h82, 0, 8'h00, 0, 1, 8'hFF, 1, 0));
        tbl.push_back(mk("t_rel",   5, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'hFF, 1, 0));
        // abort, late rdy ignored, then a clean read
        tbl.push_back(mk("a_qual",  5, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'hFF, 1, 0));
        tbl.push_back(mk("a_wait",  5, 0, 0, 8'h82, 0, 8'h00, 1, 0, 8'hFF, 1, 0));
        tbl.push_back(mk("a_fall",  5, 0, 1, 8'h82, 0, 8'h00, 1, 0, 8'hFF, 1, 0));
        tbl.push_back(mk("a_abort", 2, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'hFF, 1, 1));
        tbl.push_back(mk("a_lrdy",  1, 0, 1, 8'h82, 1, 8'hAA, 0, 0, 8'hFF, 1, 1));
        tbl.push_back(mk("a_idle",  3, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'hFF, 1, 1));
        tbl.push_back(mk("r_qual",  5, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'hFF, 1, 1));
        tbl.push_back(mk("r_wait",  3, 0, 0, 8'h82, 0, 8'h00, 1, 0, 8'hFF, 1, 1));
        tbl.push_back(mk("r_rdy",   1, 0, 0, 8'h82, 1, 8'h11, 0, 1, 8'h11, 1, 1));
        tbl.push_back(mk("r_drv",   3, 0, 0, 8'h82, 0, 8'h00, 0, 1, 8'h11, 1, 1));
        tbl.push_back(mk("r_fall",  5, 0, 1, 8'h82, 0, 8'h00, 0, 1, 8'h11, 1, 1));
        tbl.push_back(mk("r_rel",   5, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'h11, 1, 1));
        // wrong port, then a short glitch on the right port
        tbl.push_back(mk("p81_in", 10, 0, 0, 8'h81, 0, 8'h00, 0, 0, 8'h11, 1, 1));
        tbl.push_back(mk("p81_rel", 6, 0, 1, 8'h81, 0, 8'h00, 0, 0, 8'h11, 1, 1));
        tbl.push_back(mk("g_in",    2, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'h11, 1, 1));
        tbl.push_back(mk("g_rel",   8, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'h11, 1, 1));

        foreach (tbl[k]) step(tbl[k]);

        // reset while waiting
        step(mk("rw_qual",  5, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'h11, 1, 1));
        step(mk("rw_wait",  2, 0, 0, 8'h82, 0, 8'h00, 1, 0, 8'h11, 1, 1));
        step(mk("rw_rst",   1, 1, 1, 8'h82, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        step(mk("rw_idle",  4, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'h00, 0, 0));

        // reset while driving
        step(mk("rd_qual",  5, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        step(mk("rd_wait",  3, 0, 0, 8'h82, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        step(mk("rd_rdy",   1, 0, 0, 8'h82, 1, 8'h33, 0, 1, 8'h33, 0, 0));
        step(mk("rd_drv",   2, 0, 0, 8'h82, 0, 8'h00, 0, 1, 8'h33, 0, 0));
        step(mk("rd_rst",   1, 1, 1, 8'h82, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        step(mk("rd_idle",  4, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'h00, 0, 0));

        // read after reset
        step(mk("x_qual",   5, 0, 0, 8'h82, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        step(mk("x_wait",   3, 0, 0, 8'h82, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        step(mk("x_rdy",    1, 0, 0, 8'h82, 1, 8'h77, 0, 1, 8'h77, 0, 0));
        step(mk("x_drv",    3, 0, 0, 8'h82, 0, 8'h00, 0, 1, 8'h77, 0, 0));
        step(mk("x_fall",   5, 0, 1, 8'h82, 0, 8'h00, 0, 1, 8'h77, 0, 0));
        step(mk("x_rel",    3, 0, 1, 8'h82, 0, 8'h00, 0, 0, 8'h77, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
